// File: rtl/vector_frame_reducer.sv
// Per-lane frame reducer: folds each frame's valid vectors with sum/max/min/last
// and emits one registered summary vector, count and overflow flag per frame.

module vfr_lane #(
  parameter int W = 32
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] acc,
  input  logic [W-1:0] din,
  output logic [W-1:0] res,
  output logic         ovf
);
  logic [W-1:0] sum;
  assign sum = acc + din;

  always_comb begin
    res = din;
    ovf = 1'b0;
    case (op)
      2'd0: begin
        res = sum;
        // same-sign operands with a sign flip in the result
        ovf = (acc[W-1] == din[W-1]) && (sum[W-1] != acc[W-1]);
      end
      2'd1:    res = ($signed(acc) > $signed(din)) ? acc : din;
      2'd2:    res = ($signed(acc) < $signed(din)) ? acc : din;
      default: res = din;
    endcase
  end
endmodule

module vector_frame_reducer #(
  parameter int N           = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_in,
  input  logic                   eof_in,
  input  logic [1:0]             op_in,
  input  logic [DATA_WIDTH-1:0]  vector_in [N-1:0],
  output logic                   valid_out,
  output logic                   eof_out,
  output logic [DATA_WIDTH-1:0]  vector_out [N-1:0],
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic                   overflow_out
);
  typedef enum logic {EMPTY, ACCUM} state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  acc  [N-1:0];
  logic [DATA_WIDTH-1:0]  comb [N-1:0];
  logic [N-1:0]           lane_ovf;
  logic [1:0]             op_q;
  logic [COUNT_WIDTH-1:0] cnt;
  logic [COUNT_WIDTH-1:0] cnt_inc;
  logic                   ovf;

  for (genvar g = 0; g < N; g++) begin : g_lane
    vfr_lane #(.W(DATA_WIDTH)) u_lane (
      .op  (op_q),
      .acc (acc[g]),
      .din (vector_in[g]),
      .res (comb[g]),
      .ovf (lane_ovf[g])
    );
  end

  assign cnt_inc = (cnt == {COUNT_WIDTH{1'b1}}) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= EMPTY;
      op_q         <= 2'd0;
      cnt          <= '0;
      ovf          <= 1'b0;
      valid_out    <= 1'b0;
      eof_out      <= 1'b0;
      count_out    <= '0;
      overflow_out <= 1'b0;
      for (int i = 0; i < N; i++) begin
        acc[i]        <= '0;
        vector_out[i] <= '0;
      end
    end else begin
      valid_out <= 1'b0;
      eof_out   <= 1'b0;
      case (state)
        EMPTY: begin
          if (valid_in) begin
            if (eof_in) begin
              // single-vector frame bypasses the accumulator
              valid_out    <= 1'b1;
              eof_out      <= 1'b1;
              vector_out   <= vector_in;
              count_out    <= COUNT_WIDTH'(1);
              overflow_out <= 1'b0;
            end else begin
              acc   <= vector_in;
              op_q  <= op_in;
              cnt   <= COUNT_WIDTH'(1);
              ovf   <= 1'b0;
              state <= ACCUM;
            end
          end
        end
        default: begin
          if (valid_in) begin
            acc <= comb;
            cnt <= cnt_inc;
            ovf <= ovf | (|lane_ovf);
            if (eof_in) begin
              valid_out    <= 1'b1;
              eof_out      <= 1'b1;
              vector_out   <= comb;
              count_out    <= cnt_inc;
              overflow_out <= ovf | (|lane_ovf);
              state        <= EMPTY;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vector_frame_reducer.sv
// Scoreboard bench: driver feeds directed + random frames into a reference model,
// a negedge monitor pops expected results whenever the reducer pulses valid_out.

module tb_vector_frame_reducer;
  localparam int N = 4, DW = 32, CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef logic [N-1:0][DW-1:0] vec_t;
  typedef struct {
    int   cyc;
    vec_t v;
    int   cnt;
    bit   ovf;
  } exp_t;

  logic          clk = 0;
  logic          reset = 1;
  logic          valid_in = 0, eof_in = 0;
  logic [1:0]    op_in = 0;
  logic [DW-1:0] vector_in  [N-1:0];
  logic          valid_out, eof_out, overflow_out;
  logic [DW-1:0] vector_out [N-1:0];
  logic [CW-1:0] count_out;

  int   cyc = 0;
  int   compared = 0, mismatched = 0;
  exp_t sb[$];
  vec_t fq[$];
  logic [1:0] frame_op;

  vector_frame_reducer #(.N(N), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .eof_in(eof_in), .op_in(op_in),
    .vector_in(vector_in), .valid_out(valid_out), .eof_out(eof_out),
    .vector_out(vector_out), .count_out(count_out), .overflow_out(overflow_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input int a, input int b, input int c, input int d);
    vec_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  // Reference: fold the whole buffered frame with wide signed arithmetic.
  function automatic exp_t reduce(input int at);
    exp_t   e;
    longint a, b, s;
    e.cyc = at;
    e.ovf = 0;
    e.cnt = (fq.size() > CMAX) ? CMAX : fq.size();
    for (int l = 0; l < N; l++) begin
      a = longint'($signed(fq[0][l]));
      for (int k = 1; k < fq.size(); k++) begin
        b = longint'($signed(fq[k][l]));
        case (frame_op)
          2'd0: begin
            s = a + b;
            if (s > 64'sd2147483647 || s < -64'sd2147483648) e.ovf = 1;
            a = longint'($signed(s[31:0]));
          end
          2'd1: a = (b > a) ? b : a;
          2'd2: a = (b < a) ? b : a;
          default: a = b;
        endcase
      end
      e.v[l] = a[31:0];
    end
    return e;
  endfunction

  task automatic drive(input logic rst, input logic v, input logic e,
                       input logic [1:0] op, input vec_t vec);
    @(posedge clk); #1;
    reset = rst; valid_in = v; eof_in = e; op_in = op;
    for (int i = 0; i < N; i++) vector_in[i] = vec[i];
    if (rst) fq.delete();
    else if (v) begin
      if (fq.size() == 0) frame_op = op;
      fq.push_back(vec);
      if (e) begin
        sb.push_back(reduce(cyc + 1));
        fq.delete();
      end
    end
  endtask

  task automatic idle();
    drive(0, 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), mk(-1, -1, -1, -1));
  endtask

  function automatic logic [31:0] rnd_lane();
    case ($urandom_range(0, 3))
      0: return 32'($signed($urandom_range(0, 200)) - 100);
      1: return 32'h7FFF_FFF0 + 32'($urandom_range(0, 15));
      2: return 32'h8000_0000 + 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: catches missed pulses, unexpected pulses and wrong payloads.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk("missed_pulse", 64'(0), 64'(1));
    end
    if (valid_out) begin
      if (sb.size() == 0) chk("unexpected_valid", 64'(1), 64'(0));
      else begin
        e = sb.pop_front();
        chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
        for (int l = 0; l < N; l++) chk($sformatf("lane%0d", l), 64'(vector_out[l]), 64'(e.v[l]));
        chk("count", 64'(count_out), 64'(e.cnt));
        chk("overflow", 64'(overflow_out), 64'(e.ovf));
        chk("eof_out", 64'(eof_out), 64'(1));
      end
    end
  end

  initial begin
    vec_t z;
    int   len;
    logic [1:0] op;
    z = mk(0, 0, 0, 0);
    for (int i = 0; i < N; i++) vector_in[i] = '0;
    drive(1, 0, 0, 0, z);
    drive(1, 1, 1, 0, mk(3, 3, 3, 3));
    drive(0, 0, 0, 0, z);
    chk("rst_valid", 64'(valid_out), 64'(0));
    chk("rst_eof", 64'(eof_out), 64'(0));
    chk("rst_count", 64'(count_out), 64'(0));
    chk("rst_ovf", 64'(overflow_out), 64'(0));
    for (int l = 0; l < N; l++) chk("rst_vec", 64'(vector_out[l]), 64'(0));

    // sum
    drive(0, 1, 0, 0, mk(1, 2, 3, 4));
    drive(0, 1, 0, 0, mk(10, 20, 30, 40));
    drive(0, 1, 1, 0, mk(100, 200, 300, 400));
    // max, min, mid-frame op change
    drive(0, 1, 0, 1, mk(-5, 7, 0, -1));
    drive(0, 1, 1, 1, mk(3, -8, 0, -2));
    drive(0, 1, 0, 2, mk(-5, 7, 0, -1));
    drive(0, 1, 1, 2, mk(3, -8, 0, -2));
    drive(0, 1, 0, 1, mk(-5, 7, 0, -1));
    drive(0, 1, 1, 0, mk(3, -8, 0, -2));
    // overflow then clean frame
    drive(0, 1, 0, 0, mk(32'h7FFF_FFFF, 0, 0, 0));
    drive(0, 1, 1, 0, mk(1, 0, 0, 0));
    drive(0, 1, 0, 0, mk(1, 1, 1, 1));
    drive(0, 1, 1, 0, mk(1, 1, 1, 1));
    // streaming singles
    drive(0, 1, 1, 0, mk(5, 5, 5, 5));
    drive(0, 1, 1, 0, mk(6, 6, 6, 6));
    drive(0, 1, 1, 0, mk(7, 7, 7, 7));
    // idles with eof high mid-frame
    drive(0, 1, 0, 0, mk(2, 2, 2, 2));
    drive(0, 0, 1, 0, mk(50, 50, 50, 50));
    drive(0, 0, 1, 0, mk(50, 50, 50, 50));
    drive(0, 1, 1, 0, mk(3, 3, 3, 3));
    // reset mid-frame, reset coincident with EOF
    drive(0, 1, 0, 0, mk(8, 8, 8, 8));
    drive(0, 1, 0, 0, mk(8, 8, 8, 8));
    drive(1, 0, 0, 0, z);
    drive(0, 1, 1, 0, mk(1, 1, 1, 1));
    drive(0, 1, 0, 0, mk(4, 4, 4, 4));
    drive(1, 1, 1, 0, mk(4, 4, 4, 4));
    drive(0, 0, 0, 0, z);
    // count saturation
    for (int k = 0; k < 19; k++) drive(0, 1, 0, 3, mk(k, k, k, k));
    drive(0, 1, 1, 3, mk(9, 9, 9, 9));

    for (int f = 0; f < 200; f++) begin
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 20) : $urandom_range(1, 5);
      op  = 2'($urandom_range(0, 3));
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 4) == 0) idle();
        if ($urandom_range(0, 60) == 0) drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op, z);
        drive(0, 1, 1'(k == len - 1), (k == 0) ? op : 2'($urandom_range(0, 3)),
              mk(int'(rnd_lane()), int'(rnd_lane()), int'(rnd_lane()), int'(rnd_lane())));
      end
    end
    repeat (4) drive(0, 0, 0, 0, z);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
